// File: rtl/sdio_pkg.sv
// sdio_pkg: decoder states, received-frame layout, CMD53 argument fields and frame/CRC constants
package sdio_pkg;
    typedef enum logic [2:0] {IDLE, RECV, CHECK, DWAIT, DATA, DCRC} state_t;
    typedef struct packed {
        logic        dir;
        logic [5:0]  index;
        logic [31:0] arg;
        logic [6:0]  crc;
        logic        stop;
    } frame_t;
    localparam int FRAME_LEN = 48;
    localparam int CRC_LEN = 40;
    localparam int DCRC_LEN = 17;
    localparam logic [5:0] CMD53 = 6'd53;
    localparam logic [6:0] CRC7_POLY = 7'h09;
    localparam int ARG_RW = 31;
    localparam int ARG_FUNC = 28;
    localparam int FUNC_W = 3;
    localparam int ARG_BLK = 27;
    localparam int ARG_ADDR = 9;
    localparam int ADDR_FIELD_W = 17;
    localparam int CNT_W = 9;
endpackage

// File: rtl/sdio_crc7.sv
// sdio_crc7: serial MSB-first CRC7 (x^7+x^3+1), cleared to 0 by clr
module sdio_crc7 import sdio_pkg::*; (
    input  logic       sdio_clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       bit_in,
    output logic [6:0] crc
);
    logic fb;
    assign fb = bit_in ^ crc[6];
    always_ff @(posedge sdio_clk) begin
        if (rst || clr) crc <= '0;
        else if (en) crc <= {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    end
endmodule

// File: rtl/sdio_cmd_decoder.sv
// sdio_cmd_decoder: SDIO command deserialiser and CMD53 framebuffer write-window tracker; CRC7 check under SDIO_CRC7_CHECK_EN
module sdio_cmd_decoder import sdio_pkg::*; #(
    parameter int ADDR_W    = 19,
    parameter int FB_FUNC   = 1,
    parameter int BLK_BYTES = 512,
    parameter int WAIT_MAX  = 1023
) (
    input  logic              sdio_clk,
    input  logic              rst,
    input  logic              sdio_cmd,
    input  logic [3:0]        sdio_data,
    output logic              cmd_valid,
    output logic [5:0]        cmd_index,
    output logic [31:0]       cmd_arg,
    output logic              crc_err,
    output logic              frame_err,
    output logic              wr_start,
    output logic              wr_active,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [17:0]       wr_len,
    output logic              timeout
);
    state_t state, next;
    frame_t fr;
    logic [19:0] cnt;
    logic [5:0]  idx_q;
    logic [31:0] arg_q;
    logic [8:0]  blk_cnt;
    logic [17:0] len;
    logic        crc_ok, accept, wr_ok, last_nib;

    assign blk_cnt = fr.arg[CNT_W-1:0];
    assign len = fr.arg[ARG_BLK] ? 18'(32'(blk_cnt) * BLK_BYTES) : (blk_cnt == '0 ? 18'd512 : 18'(blk_cnt));
    assign accept = fr.dir && fr.stop && crc_ok;
    assign wr_ok = accept && fr.index == CMD53 && fr.arg[ARG_RW] && fr.arg[ARG_FUNC +: FUNC_W] == FUNC_W'(FB_FUNC)
                   && (!fr.arg[ARG_BLK] || blk_cnt != '0);
    assign last_nib = cnt == 20'({wr_len, 1'b0}) - 20'd1;

`ifdef SDIO_CRC7_CHECK_EN
    logic [6:0] crc;
    // start bit is 0 and the CRC inits to 0, so only the 39 bits after it need feeding
    sdio_crc7 u_crc7 (
        .sdio_clk,
        .rst,
        .clr(state == IDLE),
        .en(state == RECV && cnt < 20'(CRC_LEN - 1)),
        .bit_in(sdio_cmd),
        .crc
    );
    assign crc_ok = crc == fr.crc;
`else
    logic unused_crc;
    assign unused_crc = ^fr.crc;
    assign crc_ok = 1'b1;
`endif

    always_ff @(posedge sdio_clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            fr <= '0;
        end else begin
            state <= next;
            cnt <= (next != state || state == IDLE) ? '0 : cnt + 20'd1;
            if (state == RECV) fr <= {fr[FRAME_LEN-3:0], sdio_cmd};
        end
    end

    always_ff @(posedge sdio_clk) begin
        if (rst) begin
            idx_q <= '0;
            arg_q <= '0;
            wr_addr <= '0;
            wr_len <= '0;
        end else if (state == CHECK) begin
            if (accept) begin
                idx_q <= fr.index;
                arg_q <= fr.arg;
            end
            if (wr_ok) begin
                wr_addr <= ADDR_W'(fr.arg[ARG_ADDR +: ADDR_FIELD_W]);
                wr_len <= len;
            end
        end
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:  next = sdio_cmd ? IDLE : RECV;
            RECV:  next = cnt == 20'(FRAME_LEN - 2) ? CHECK : RECV;
            CHECK: next = wr_ok ? DWAIT : IDLE;
            DWAIT: next = sdio_data == 4'h0 ? DATA : (cnt == 20'(WAIT_MAX - 1) ? IDLE : DWAIT);
            DATA:  next = last_nib ? DCRC : DATA;
            DCRC:  next = cnt == 20'(DCRC_LEN - 1) ? IDLE : DCRC;
            default: next = IDLE;
        endcase
    end

    always_comb begin
        cmd_valid = state == CHECK && accept;
        frame_err = state == CHECK && fr.dir && !fr.stop;
        crc_err = state == CHECK && fr.dir && fr.stop && !crc_ok;
        timeout = state == DWAIT && sdio_data != 4'h0 && cnt == 20'(WAIT_MAX - 1);
        wr_active = state == DATA;
        wr_start = state == DATA && cnt == '0;
        cmd_index = cmd_valid ? fr.index : idx_q;
        cmd_arg = cmd_valid ? fr.arg : arg_q;
    end
endmodule
